alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 32-bit add/sub/and/or ALU.
- Adds xor, signed and unsigned set-less-than, and an iterative shift-add multiply.
- Adds zero/negative/carry/overflow flags and registered outputs with valid/ready flow control.
- Sits between the datapath issue logic and writeback; one operation is in flight at a time.

Parameters:
- N, 32, operand/result width (N >= 2)
- MUL_EN, 1, 1 enables the iterative multiply; 0 makes op 111 a single-cycle op returning 0 with all flags 0

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  operation offered
- in_ready  output  1  block accepts the operation this cycle
- a  input  N  operand A
- b  input  N  operand B
- ctrl  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 mul
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes the result
- result  output  N  registered result
- zero  output  1  result == 0
- neg  output  1  result[N-1]
- carry  output  1  add: carry-out; sub: 1 = no borrow (a + ~b + 1 carry-out); all other ops 0
- overflow  output  1  add/sub: signed overflow; mul: unsigned 2N-bit product does not fit in N bits; all other ops 0
- busy  output  1  multiply in progress

Behaviour:
- Reset (async, active-high):
  - state=IDLE; result/flags=0; out_valid=0; busy=0; counter=0.
  - in_ready is forced 0 while reset is high.
  - Reset mid-multiply aborts the operation; no partial result is ever presented.
- States:
  - IDLE: out_valid=0; in_ready=1.
  - MUL: busy=1; in_ready=0; out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Acceptance: accept = in_valid & in_ready. Operands and ctrl are captured on the accepting edge.
- Single-cycle ops (000-110, and 111 when MUL_EN=0):
  - On accept, compute combinationally and register result plus flags; go to DONE.
  - out_valid is high the cycle after acceptance (latency 1).
- Multiply (111, MUL_EN=1):
  - On accept, load multiplicand, multiplier and a 2N-bit accumulator = 0; counter=0; go to MUL.
  - Each MUL cycle: if multiplier LSB=1, add the shifted multiplicand; shift; counter++.
  - After N MUL cycles: result = low N bits; overflow = |high N bits; carry=0; go to DONE.
  - out_valid is first high N+1 cycles after the acceptance cycle.
- DONE:
  - result and flags are held stable while out_ready=0.
  - On out_ready=1 with accept: the next op is taken on the same edge. A single-cycle op stays in DONE with the new result, giving one result per cycle back-to-back. A mul goes to MUL.
  - On out_ready=1 without accept: go to IDLE.
- Arithmetic:
  - sub = a + ~b + 1, computed at N+1 bits; carry = bit N.
  - Add/sub overflow = (a[N-1]==b'[N-1]) & (sum[N-1]!=a[N-1]), where b' is the post-inversion operand.
  - slt = signed a<b, zero-extended to N bits.
  - sltu = unsigned a<b.
  - zero and neg are computed from the final N-bit result for every op.
- Boundaries:
  - in_valid while busy is ignored; the upstream holds it.
  - ctrl and operand changes during MUL have no effect.
  - Counter width is $clog2(N)+1; wrap is impossible.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (3-bit opcodes above)
  - alu_state_t enum (IDLE, MUL, DONE)
  - alu_flags_t struct (zero, neg, carry, overflow)
- Sub-module alu_core:
  - combinational add/sub/logic/compare for N bits
  - returns result and alu_flags_t
  - instantiated once; the multiply sequencer stays in alu_pipe.

Test Plan (N=32, MUL_EN=1):
- add 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle out_valid=1, result=0x80000000, neg=1, overflow=1, carry=0, zero=0.
- sub 5-5 -> result 0, zero=1, carry=1, overflow=0. slt 0xFFFFFFFF,1 -> 1. sltu 0xFFFFFFFF,1 -> 0.
- and/or/xor 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0; carry=overflow=0.
- mul 7*6 -> busy=1 and in_ready=0 for 32 cycles; out_valid exactly 33 cycles after acceptance; result=42, overflow=0. mul 0x10000*0x10000 -> result=0, zero=1, overflow=1.
- out_ready=0 for 5 cycles after an add -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid held and 4 queued adds -> one result per cycle, no gaps, no drops.
- reset pulsed at MUL cycle 10 -> out_valid=0 and busy=0 immediately (async). After release: IDLE, in_ready=1; following add 2+3 -> result=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcodes, sequencer states and result flags.
package alu_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpSlt  = 3'b101,
    OpSltu = 3'b110,
    OpMul  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDone = 2'b10
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/logic/compare datapath; the multiply opcode yields 0 with all flags clear.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_t      op,
  output logic [N-1:0] result,
  output alu_flags_t   flags
);

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  // Subtraction reuses the adder as a + ~b + 1.
  assign is_sub = (op == OpSub);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};

  always_comb begin
    result = '0;
    flags  = '0;
    unique case (op)
      OpAdd, OpSub: begin
        result         = sum[N-1:0];
        flags.carry    = sum[N];
        flags.overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
      end
      OpAnd:  result = a & b;
      OpOr:   result = a | b;
      OpXor:  result = a ^ b;
      OpSlt:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: result = {{(N-1){1'b0}}, (a < b)};
      OpMul:  result = '0;
    endcase
    if (op != OpMul) begin
      flags.zero = (result == '0);
      flags.neg  = result[N-1];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with registered result and flags; one op in flight, iterative shift-add multiply.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         neg,
  output logic         carry,
  output logic         overflow,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(N) + 1;

  alu_state_t     state_q;
  logic [N-1:0]   result_q;
  alu_flags_t     flags_q;
  logic [2*N-1:0] mcand_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   mplier_q;
  logic [CntW-1:0] cnt_q;

  alu_op_t        op;
  logic [N-1:0]   core_result;
  alu_flags_t     core_flags;
  logic           accept;
  logic           start_mul;
  logic           last_step;
  logic [2*N-1:0] acc_next;

  assign op = alu_op_t'(ctrl);

  alu_core #(.N(N)) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (core_result),
    .flags  (core_flags)
  );

  assign in_ready  = !reset && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign start_mul = MUL_EN && (op == OpMul);
  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_step = (cnt_q == CntW'(N - 1));

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMul);
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (start_mul) begin
              mcand_q  <= {{N{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              result_q <= core_result;
              flags_q  <= core_flags;
              state_q  <= StDone;
            end
          end else if ((state_q == StDone) && out_ready) begin
            state_q <= StIdle;
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Final step publishes the low half; any high-half bit means the product overflowed.
          if (last_step) begin
            result_q          <= acc_next[N-1:0];
            flags_q.zero      <= (acc_next[N-1:0] == '0);
            flags_q.neg       <= acc_next[N-1];
            flags_q.carry     <= 1'b0;
            flags_q.overflow  <= |acc_next[2*N-1:N];
            state_q           <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
